// File: rtl/puerto_entrada.sv
// Debounced 8-bit input port: synchronizes switch levels, accepts a level after it has
// been stable DEBOUNCE cycles, and reports masked changes and rising edges to a CPU.
module puerto_entrada #(
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pins,
    input  logic       re,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wd,
    output logic [7:0] rd,
    output logic       irq
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE - 1);

    logic [7:0] s1_r;
    logic [7:0] s2_r;
    logic [7:0] cand_r;
    logic [7:0] cnt_r;
    logic [7:0] data_r;
    logic [7:0] mask_r;
    logic [7:0] edge_r;
    logic       nuevo_r;
    logic       overflow_r;
    logic       irq_r;

    logic       accept_s;
    logic       rd_clear_s;
    logic       nuevo_set_s;
    logic [7:0] edge_set_s;
    logic [7:0] edge_clr_s;

    // Decode the accept event and the CPU side effects for this cycle
    always_comb begin
        accept_s    = (s2_r == cand_r) && (cnt_r == CNT_MAX) && (cand_r != data_r);
        rd_clear_s  = re && (addr == 2'd0);
        nuevo_set_s = accept_s && (((cand_r ^ data_r) & mask_r) != 8'h00);
        if (accept_s) begin
            edge_set_s = cand_r & ~data_r & mask_r;
        end else begin
            edge_set_s = 8'h00;
        end
        if (we && (addr == 2'd3)) begin
            edge_clr_s = wd;
        end else begin
            edge_clr_s = 8'h00;
        end
    end

    // Synchronizer and debounce datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r   <= 8'h00;
            s2_r   <= 8'h00;
            cand_r <= 8'h00;
            cnt_r  <= 8'h00;
            data_r <= 8'h00;
        end else begin
            s1_r <= pins;
            s2_r <= s1_r;
            if (s2_r != cand_r) begin
                cand_r <= s2_r;
                cnt_r  <= 8'h00;
            end else if (accept_s) begin
                data_r <= cand_r;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // CPU-visible status, mask and edge registers; sets win over clears
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_r     <= 8'hFF;
            edge_r     <= 8'h00;
            nuevo_r    <= 1'b0;
            overflow_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            irq_r  <= nuevo_r;
            edge_r <= (edge_r & ~edge_clr_s) | edge_set_s;
            if (we && (addr == 2'd2)) begin
                mask_r <= wd;
            end else begin
                mask_r <= mask_r;
            end
            if (nuevo_set_s) begin
                nuevo_r <= 1'b1;
            end else if (rd_clear_s) begin
                nuevo_r <= 1'b0;
            end else begin
                nuevo_r <= nuevo_r;
            end
            // An accept while an unread event is pending counts as overflow
            if (rd_clear_s) begin
                overflow_r <= 1'b0;
            end else if (accept_s && nuevo_r) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Register read mux
    always_comb begin
        case (addr)
            2'd0:    rd = data_r;
            2'd1:    rd = {6'b000000, overflow_r, nuevo_r};
            2'd2:    rd = mask_r;
            2'd3:    rd = edge_r;
            default: rd = 8'h00;
        endcase
    end

    assign irq = irq_r;

endmodule

// File: doc/puerto_entrada.md
PUERTO_ENTRADA -- requirements
Module: puerto_entrada

Interface
REQ-001 Parameter DEBOUNCE, default 16, range 2..255: number of consecutive stable clock cycles required before a pin value is accepted.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-004 Port pins, input, 8: external switch/button levels, asynchronous to clk.
REQ-005 Port re, input, 1: CPU read strobe; read side effects are applied at the rising edge where re=1.
REQ-006 Port we, input, 1: CPU write strobe.
REQ-007 Port addr, input, 2: register select; 0=DATA (ro), 1=STATUS (ro), 2=MASK (rw), 3=EDGE (rw, write-1-to-clear).
REQ-008 Port wd, input, 8: CPU write data.
REQ-009 Port rd, output, 8: register selected by addr; combinational, independent of re.
REQ-010 Port irq, output, 1: registered copy of STATUS.nuevo.

Function
REQ-011 pins SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-012 Debounce state SHALL be: an 8-bit candidate register, plus an 8-bit saturating counter cnt.
REQ-013 If s2 != candidate: candidate <= s2 and cnt <= 0.
REQ-014 Else if cnt == DEBOUNCE-1 and candidate != DATA: accept (DATA <= candidate).
REQ-015 Else cnt increments, saturating at DEBOUNCE-1.
REQ-016 Latency: a pin change held stable SHALL appear in DATA after rising edge DEBOUNCE+3, counting the first edge that samples the new level as edge 1.
REQ-017 Any glitch shorter than DEBOUNCE cycles after synchronization SHALL NOT change DATA, EDGE or STATUS.
REQ-018 On accept: if ((candidate ^ DATA) & MASK) != 0, nuevo <= 1.
REQ-019 On accept, if nuevo was already 1 and not being cleared that cycle, overflow <= 1.
REQ-020 On accept: EDGE[i] <= EDGE[i] | (candidate[i] & ~DATA[i] & MASK[i]); this captures rising edges only.
REQ-021 STATUS SHALL read {6'b0, overflow, nuevo}.
REQ-022 re=1 with addr=0 SHALL clear nuevo and overflow at that edge.
REQ-023 Simultaneous accept and DATA read: nuevo SHALL remain 1 if the accept sets it, and overflow SHALL NOT be set.
REQ-024 rd SHALL return the pre-edge DATA value.
REQ-025 we=1 with addr=2: MASK <= wd.
REQ-026 we=1 with addr=3: EDGE <= EDGE & ~wd.
REQ-027 Set SHALL win over clear on the same bit in the same cycle.
REQ-028 Writes to addr 0 and addr 1 SHALL be ignored.
REQ-029 re with addr 1..3 SHALL have no side effects.
REQ-030 irq SHALL equal nuevo delayed one cycle, and SHALL deassert one cycle after the clearing read.
REQ-031 Simultaneous re and we to the same address SHALL both take effect.

Reset
REQ-032 While reset=0, regardless of clk: s1, s2, candidate, cnt, DATA, EDGE, nuevo, overflow and irq SHALL be 0, and MASK SHALL be 8'hFF.
REQ-033 Reset asserted mid-debounce SHALL discard the in-progress candidate.
REQ-034 After reset release, a pin level of 8'h00 SHALL produce no accept; any non-zero pin level SHALL be debounced as a normal change.
REQ-035 Reset deassertion SHALL be synchronized by the system; the block SHALL tolerate reset release at any clk phase.

Verification
REQ-036 DEBOUNCE=16, pins 00->5A held: DATA=5A after edge 19; nuevo=1 at edge 19; irq=1 at edge 20; EDGE=5A.
REQ-037 pins 00->FF for 10 cycles then back to 00: DATA, EDGE and STATUS SHALL stay 0 throughout.
REQ-038 MASK=0F, pins 00->F0 held: DATA=F0, nuevo=0, EDGE=00, irq stays 0.
REQ-039 Two accepted changes (00->01, then 01->03) with no read: STATUS=03; read addr 0 returns 03, then STATUS=00 and irq=0 one cycle later.
REQ-040 Accept of 03->07 on the same edge as a DATA read: rd=03 during the read, afterwards STATUS=01; EDGE=07 before write wd=05 to addr 3, and EDGE=02 after.
REQ-041 reset pulsed low at cnt=8 of a pending 00->AA change: all outputs 0 and MASK=FF immediately; DATA=AA only DEBOUNCE+3 edges after reset release.
